// File: rtl/pipe_flow_ctrl_pkg.sv
// Shared types for the LC-3b pipeline flow controller: register index type,
// flow FSM states, the NOP word the latches load on a bubble, and the
// saturating increment used by the stall watchdog.
package pipe_flow_ctrl_pkg;

  localparam int LC3B_REG_W = 3;
  localparam int WDOG_W     = 16;

  typedef logic [LC3B_REG_W-1:0] lc3b_reg;

  typedef enum logic {
    FLOW_RUN      = 1'b0,
    FLOW_MEM_WAIT = 1'b1
  } flow_state_t;

  // Instruction word written into a latch that is loaded with a bubble.
  localparam logic [15:0] LC3B_NOP = 16'h0000;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [WDOG_W-1:0] sat_inc(input logic [WDOG_W-1:0] v);
    return (v == {WDOG_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/pipe_flow_ctrl_hazard_detect.sv
// hazard_detect: purely combinational load-use compare. Flags when decode
// reads a register that the load ahead of it is about to write. Kept
// separate so the forwarding unit can reuse the same compare later.
module hazard_detect #(
  parameter int REG_IDX_W = 3
) (
  input  logic [REG_IDX_W-1:0] src1,
  input  logic [REG_IDX_W-1:0] src2,
  input  logic                 src1_used,
  input  logic                 src2_used,
  input  logic                 is_load,
  input  logic [REG_IDX_W-1:0] dest,
  output logic                 hazard
);

  // A source only matters when decode actually reads it.
  always_comb begin
    hazard = is_load && ((src1_used && (src1 == dest)) ||
                         (src2_used && (src2 == dest)));
  end

endmodule

// File: rtl/pipe_flow_ctrl.sv
// pipe_flow_ctrl: parametrised flow controller for the LC-3b pipeline.
// Drives PC load/redirect and per-latch load/bubble enables, tracks valid
// bits, and runs a stall watchdog that raises a sticky hang_err.
// Optional build macro PIPE_FLOW_PERF_EN adds four 32-bit stall/flush
// counters (perf_stall_mem, perf_stall_lu, perf_stall_fetch, perf_flush).
module pipe_flow_ctrl
  import pipe_flow_ctrl_pkg::*;
#(
  parameter int NUM_LATCHES  = 4,
  parameter int NUM_DPORTS   = 1,
  parameter int REG_IDX_W    = 3,
  parameter int REDIRECT_IDX = 3,
  parameter int LOADUSE_IDX  = 1,
  parameter int WDOG_LIMIT   = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   if_ready,
  input  logic [NUM_DPORTS-1:0]  dmem_busy,
  input  logic [REG_IDX_W-1:0]   id_src1,
  input  logic [REG_IDX_W-1:0]   id_src2,
  input  logic                   id_src1_used,
  input  logic                   id_src2_used,
  input  logic                   lu_is_load,
  input  logic [REG_IDX_W-1:0]   lu_dest,
  input  logic                   redirect_req,
  output logic                   load_pc,
  output logic                   pc_redirect,
  output logic [NUM_LATCHES-1:0] load_latch,
  output logic [NUM_LATCHES-1:0] bubble,
  output logic [NUM_LATCHES-1:0] stage_valid,
  output logic                   hang_err
`ifdef PIPE_FLOW_PERF_EN
  ,
  output logic [31:0]            perf_stall_mem,
  output logic [31:0]            perf_stall_lu,
  output logic [31:0]            perf_stall_fetch,
  output logic [31:0]            perf_flush
`endif
);

  localparam logic [WDOG_W-1:0] WDOG_LIMIT_W = WDOG_W'(WDOG_LIMIT);

  logic [NUM_LATCHES-1:0] valid_reg;
  flow_state_t            state_reg, state_next;
  logic [WDOG_W-1:0]      wdog_reg;
  logic [WDOG_W-1:0]      wdog_inc;
  logic                   hang_reg;

  logic dmem_stall;
  logic redirect_act;
  logic lu_raw;
  logic lu_hazard;

  hazard_detect #(
    .REG_IDX_W (REG_IDX_W)
  ) u_hazard (
    .src1      (id_src1),
    .src2      (id_src2),
    .src1_used (id_src1_used),
    .src2_used (id_src2_used),
    .is_load   (lu_is_load),
    .dest      (lu_dest),
    .hazard    (lu_raw)
  );

  // Qualify requests with the valid bits of the latches they come from, so
  // squashed instructions can never redirect or stall the pipe.
  always_comb begin
    dmem_stall   = |dmem_busy;
    redirect_act = redirect_req && valid_reg[REDIRECT_IDX];
    lu_hazard    = lu_raw && valid_reg[LOADUSE_IDX] && valid_reg[0];
    wdog_inc     = sat_inc(wdog_reg);
  end

  // Priority arbitration of stall causes plus flow FSM next state.
  always_comb begin
    load_pc     = 1'b1;
    pc_redirect = 1'b0;
    load_latch  = '1;
    bubble      = '0;
    state_next  = state_reg;

    if (reset) begin
      // Refill the whole pipe with bubbles while reset is held.
      load_pc = 1'b0;
      bubble  = '1;
    end else if (dmem_stall) begin
      // Freeze everything; a concurrent redirect re-presents next cycle.
      load_pc    = 1'b0;
      load_latch = '0;
    end else if (redirect_act) begin
      // Resolving instruction moves on; everything younger is squashed.
      pc_redirect = 1'b1;
      for (int i = 0; i < NUM_LATCHES; i++) begin
        if (i <= REDIRECT_IDX) bubble[i] = 1'b1;
      end
    end else if (lu_hazard) begin
      load_pc                = 1'b0;
      load_latch[0]          = 1'b0;
      bubble[LOADUSE_IDX]    = 1'b1;
    end else if (!if_ready) begin
      load_pc   = 1'b0;
      bubble[0] = 1'b1;
    end

    case (state_reg)
      FLOW_RUN:      if (dmem_stall)  state_next = FLOW_MEM_WAIT;
      FLOW_MEM_WAIT: if (!dmem_stall) state_next = FLOW_RUN;
      default:                        state_next = FLOW_RUN;
    endcase
  end

  // Flow FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_reg <= FLOW_RUN;
    else       state_reg <= state_next;
  end

  // Per-latch valid bits: a loaded latch takes its predecessor's valid bit
  // unless it is bubbled; an unloaded latch keeps its own.
  for (genvar gi = 0; gi < NUM_LATCHES; gi++) begin : g_valid
    if (gi == 0) begin : g_first
      // Valid of IF/ID comes straight from the fetch side.
      always_ff @(posedge clk) begin
        if (reset)              valid_reg[gi] <= 1'b0;
        else if (load_latch[gi]) valid_reg[gi] <= ~bubble[gi];
      end
    end else begin : g_rest
      // Valid shifts down from the previous latch.
      always_ff @(posedge clk) begin
        if (reset)              valid_reg[gi] <= 1'b0;
        else if (load_latch[gi]) valid_reg[gi] <= valid_reg[gi-1] & ~bubble[gi];
      end
    end
  end

  // Stall watchdog: counts consecutive cycles without PC progress and
  // latches hang_err once the limit is reached.
  always_ff @(posedge clk) begin
    if (reset) begin
      wdog_reg <= '0;
      hang_reg <= 1'b0;
    end else if (load_pc) begin
      wdog_reg <= '0;
    end else if (!pc_redirect) begin
      wdog_reg <= wdog_inc;
      if (wdog_inc >= WDOG_LIMIT_W) hang_reg <= 1'b1;
    end
  end

  assign stage_valid = valid_reg;
  assign hang_err    = hang_reg;

`ifdef PIPE_FLOW_PERF_EN
  logic win_mem, win_flush, win_lu, win_fetch;

  // Exactly one cause wins in any non-reset cycle with a stall or flush.
  always_comb begin
    win_mem   = !reset && dmem_stall;
    win_flush = !reset && !dmem_stall && redirect_act;
    win_lu    = !reset && !dmem_stall && !redirect_act && lu_hazard;
    win_fetch = !reset && !dmem_stall && !redirect_act && !lu_hazard && !if_ready;
  end

  // Free-running wrap-around counters of the winning stall/flush cause.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_mem   <= '0;
      perf_stall_lu    <= '0;
      perf_stall_fetch <= '0;
      perf_flush       <= '0;
    end else begin
      if (win_mem)   perf_stall_mem   <= perf_stall_mem + 32'd1;
      if (win_lu)    perf_stall_lu    <= perf_stall_lu + 32'd1;
      if (win_fetch) perf_stall_fetch <= perf_stall_fetch + 32'd1;
      if (win_flush) perf_flush       <= perf_flush + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// Directed testbench for pipe_flow_ctrl (4 latches, WDOG_LIMIT=8).
// Inputs change 1 time unit after the rising edge; combinational outputs are
// checked 1 unit later, registered state 1 unit after the next edge.
module tb_pipe_flow_ctrl;
  import pipe_flow_ctrl_pkg::*;

  localparam int NL = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_ready;
  logic [0:0]    dmem_busy;
  logic [2:0]    id_src1, id_src2, lu_dest;
  logic          id_src1_used, id_src2_used, lu_is_load, redirect_req;
  logic          load_pc, pc_redirect, hang_err;
  logic [NL-1:0] load_latch, bubble, stage_valid;
`ifdef PIPE_FLOW_PERF_EN
  logic [31:0]   perf_stall_mem, perf_stall_lu, perf_stall_fetch, perf_flush;
`endif

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  always #5 clk = ~clk;

  pipe_flow_ctrl #(
    .NUM_LATCHES  (NL),
    .NUM_DPORTS   (1),
    .REG_IDX_W    (3),
    .REDIRECT_IDX (3),
    .LOADUSE_IDX  (1),
    .WDOG_LIMIT   (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .if_ready     (if_ready),
    .dmem_busy    (dmem_busy),
    .id_src1      (id_src1),
    .id_src2      (id_src2),
    .id_src1_used (id_src1_used),
    .id_src2_used (id_src2_used),
    .lu_is_load   (lu_is_load),
    .lu_dest      (lu_dest),
    .redirect_req (redirect_req),
    .load_pc      (load_pc),
    .pc_redirect  (pc_redirect),
    .load_latch   (load_latch),
    .bubble       (bubble),
    .stage_valid  (stage_valid),
    .hang_err     (hang_err)
`ifdef PIPE_FLOW_PERF_EN
    ,
    .perf_stall_mem   (perf_stall_mem),
    .perf_stall_lu    (perf_stall_lu),
    .perf_stall_fetch (perf_stall_fetch),
    .perf_flush       (perf_flush)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Check all combinational control outputs at once.
  task automatic check_ctrl(input string tag, input logic lpc, input logic redir,
                            input logic [NL-1:0] ll, input logic [NL-1:0] bb);
    check({tag, ".load_pc"},     32'(load_pc),     32'(lpc));
    check({tag, ".pc_redirect"}, 32'(pc_redirect), 32'(redir));
    check({tag, ".load_latch"},  32'(load_latch),  32'(ll));
    check({tag, ".bubble"},      32'(bubble),      32'(bb));
  endtask

  // Advance one clock and log the transaction.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    $display("[TB] cyc %0d: valid=%b hang=%0b", cyc, stage_valid, hang_err);
  endtask

  initial begin
    reset = 1'b1; if_ready = 1'b0; dmem_busy = 1'b0;
    id_src1 = 3'd0; id_src2 = 3'd0; lu_dest = 3'd0;
    id_src1_used = 1'b0; id_src2_used = 1'b0; lu_is_load = 1'b0; redirect_req = 1'b0;

    // Reset: bubble everything, no PC load.
    #1;
    check_ctrl("rst", 1'b0, 1'b0, 4'b1111, 4'b1111);
    tick(); tick();
    check("rst.valid", 32'(stage_valid), 32'h0);
    check("rst.hang",  32'(hang_err),    32'h0);

    // Fill: valid bits shift in one per cycle.
    #0 reset = 1'b0; if_ready = 1'b1;
    #1;
    check_ctrl("fill0", 1'b1, 1'b0, 4'b1111, 4'b0000);
    tick(); check("fill.v1", 32'(stage_valid), 32'b0001); check("fill.lpc1", 32'(load_pc), 32'h1);
    tick(); check("fill.v2", 32'(stage_valid), 32'b0011); check("fill.lpc2", 32'(load_pc), 32'h1);
    tick(); check("fill.v3", 32'(stage_valid), 32'b0111); check("fill.lpc3", 32'(load_pc), 32'h1);
    tick(); check("fill.v4", 32'(stage_valid), 32'b1111);

    // Data memory stall for 3 cycles: full freeze, valid held.
    dmem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_ctrl("dmem", 1'b0, 1'b0, 4'b0000, 4'b0000);
      tick();
      check("dmem.valid", 32'(stage_valid), 32'b1111);
      check("dmem.state", 32'(dut.state_reg), 32'(FLOW_MEM_WAIT));
    end
    dmem_busy = 1'b0;
    #1;
    check_ctrl("dmem.resume", 1'b1, 1'b0, 4'b1111, 4'b0000);
    tick();
    check("dmem.run", 32'(dut.state_reg), 32'(FLOW_RUN));

    // Load in ID/EX, src2 matches but is unused, src1 differs: no hazard.
    lu_is_load = 1'b1; lu_dest = 3'd3; id_src1 = 3'd2; id_src1_used = 1'b1;
    id_src2 = 3'd3; id_src2_used = 1'b0;
    #1;
    check_ctrl("lu.none", 1'b1, 1'b0, 4'b1111, 4'b0000);
    tick();
    // Real hazard through src1.
    id_src1 = 3'd3;
    #1;
    check_ctrl("lu.hit", 1'b0, 1'b0, 4'b1110, 4'b0010);
    tick();
    check("lu.valid", 32'(stage_valid), 32'b1101);
    // Same inputs, but ID/EX now holds a bubble: hazard gated off.
    #1;
    check_ctrl("lu.gated", 1'b1, 1'b0, 4'b1111, 4'b0000);
    tick();
    check("lu.valid2", 32'(stage_valid), 32'b1011);
    lu_is_load = 1'b0; id_src1_used = 1'b0;
    tick(); tick();
    check("lu.refill", 32'(stage_valid), 32'b1111);

    // Fetch stall for one cycle.
    if_ready = 1'b0;
    #1;
    check_ctrl("fetch", 1'b0, 1'b0, 4'b1111, 4'b0001);
    tick();
    check("fetch.valid", 32'(stage_valid), 32'b1110);
    if_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("fetch.refill", 32'(stage_valid), 32'b1111);

    // Redirect with a full pipe squashes everything.
    redirect_req = 1'b1;
    #1;
    check_ctrl("redir", 1'b1, 1'b1, 4'b1111, 4'b1111);
    tick();
    check("redir.valid", 32'(stage_valid), 32'b0000);
    // Redirect request from an invalid latch is ignored.
    #1;
    check_ctrl("redir.gated", 1'b1, 1'b0, 4'b1111, 4'b0000);
    tick();
    check("redir.valid2", 32'(stage_valid), 32'b0001);
    redirect_req = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("redir.refill", 32'(stage_valid), 32'b1111);

    // Redirect together with a memory stall: freeze wins, redirect follows.
    redirect_req = 1'b1; dmem_busy = 1'b1;
    #1;
    check_ctrl("rd_dm.freeze", 1'b0, 1'b0, 4'b0000, 4'b0000);
    tick();
    check("rd_dm.valid", 32'(stage_valid), 32'b1111);
    dmem_busy = 1'b0;
    #1;
    check_ctrl("rd_dm.redir", 1'b1, 1'b1, 4'b1111, 4'b1111);
    tick();
    check("rd_dm.valid2", 32'(stage_valid), 32'b0000);
    redirect_req = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("rd_dm.refill", 32'(stage_valid), 32'b1111);

    // Watchdog: 8 consecutive stall cycles set hang_err.
    dmem_busy = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    check("wdog.7", 32'(hang_err), 32'h0);
    tick();
    check("wdog.8", 32'(hang_err), 32'h1);
    dmem_busy = 1'b0;
    #1;
    check("wdog.resume", 32'(load_pc), 32'h1);
    tick(); tick();
    check("wdog.sticky", 32'(hang_err), 32'h1);

`ifdef PIPE_FLOW_PERF_EN
    check("perf.mem",   perf_stall_mem,   32'd12);
    check("perf.lu",    perf_stall_lu,    32'd1);
    check("perf.fetch", perf_stall_fetch, 32'd1);
    check("perf.flush", perf_flush,       32'd2);
`endif

    // Reset in the middle of a memory stall overrides the stall.
    dmem_busy = 1'b1; reset = 1'b1;
    #1;
    check_ctrl("rst_mid", 1'b0, 1'b0, 4'b1111, 4'b1111);
    tick();
    check("rst_mid.valid", 32'(stage_valid), 32'h0);
    check("rst_mid.hang",  32'(hang_err),    32'h0);
    reset = 1'b0; dmem_busy = 1'b0;
    tick();
    check("rst_mid.refill", 32'(stage_valid), 32'b0001);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
